// File: rtl/hist_eq_pkg.sv
// Shared types and constants for the histogram-equalizer frame sequencer.
package hist_eq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    HIST  = 3'd2,
    EQ    = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam int          SP_DEPTH   = 256;
  localparam int          SP_AW      = 16;
  localparam int          SP_DW      = 36;
  localparam int          CDF_W      = 20;
  localparam int          TO_W       = 20;
  // Tag field [35:20] is zero, never the 16'hAAAA valid marker, so a cleared bin reads empty.
  localparam logic [35:0] CLEAR_WORD = 36'h000000000;

endpackage

// File: rtl/hist_eq_sequencer_watchdog.sv
// Phase watchdog: counts enabled cycles since the last clear and flags when
// the current phase has used up its TIMEOUT cycle budget.
module phase_watchdog #(
  parameter logic [hist_eq_pkg::TO_W-1:0] TIMEOUT = 20'd1048575
) (
  input  logic clock,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [hist_eq_pkg::TO_W-1:0] count_reg;

  // Expires during the TIMEOUT-th enabled cycle so the abort edge ends that cycle.
  assign expired = en && (count_reg >= TIMEOUT - 1'b1);

  // Cycle counter: restarts on every phase change, holds once expired.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/hist_eq_sequencer.sv
// Frame-level sequencer: clears scratchpad bins, runs the histogram/CDF
// pipeline, latches cdf_min, runs the output mapper, then reports completion.
// A watchdog aborts a stalled HIST or EQ phase into ERR.
module hist_eq_sequencer #(
  parameter int                             SP_DEPTH   = hist_eq_pkg::SP_DEPTH,
  parameter int                             SP_AW      = hist_eq_pkg::SP_AW,
  parameter logic [hist_eq_pkg::SP_DW-1:0]  CLEAR_WORD = hist_eq_pkg::CLEAR_WORD,
  parameter logic [hist_eq_pkg::TO_W-1:0]   TIMEOUT    = 20'd1048575
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic                          frame_req,
  input  logic                          frame_base,
  input  logic                          err_clr,
  input  logic                          hist_done,
  input  logic                          cdf_valid,
  input  logic [hist_eq_pkg::CDF_W-1:0] cdf_min,
  input  logic                          eq_done,
  output logic                          hist_start,
  output logic                          base_offset,
  output logic                          eq_start,
  output logic [hist_eq_pkg::CDF_W-1:0] cdf_min_q,
  output logic                          clr_we,
  output logic [SP_AW-1:0]              clr_addr,
  output logic [hist_eq_pkg::SP_DW-1:0] clr_data,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          error
);

  import hist_eq_pkg::*;

  state_t state_reg, state_next;
  logic   cdf_seen_reg;
  logic   accept;
  logic   clear_last;
  logic   wd_clr, wd_en, wd_expired;

  assign accept     = (state_reg == IDLE) && frame_req;
  assign clear_last = (clr_addr == SP_AW'(SP_DEPTH - 1));
  assign wd_en      = (state_reg == HIST) || (state_reg == EQ);
  assign wd_clr     = (state_next != state_reg);
  assign clr_data   = CLEAR_WORD;

  phase_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock   (clock),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; completion beats a coincident watchdog expiry.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (frame_req) state_next = CLEAR;
      CLEAR:   if (clear_last) state_next = HIST;
      HIST:    if (hist_done) state_next = EQ;
               else if (wd_expired) state_next = ERR;
      EQ:      if (eq_done) state_next = DONE;
               else if (wd_expired) state_next = ERR;
      DONE:    state_next = IDLE;
      ERR:     if (err_clr) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control outputs registered from the next state so they track the state register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      hist_start <= 1'b0;
      eq_start   <= 1'b0;
      clr_we     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
    end else begin
      hist_start <= (state_next == HIST);
      eq_start   <= (state_next == EQ);
      clr_we     <= (state_next == CLEAR);
      busy       <= (state_next != IDLE) && (state_next != ERR);
      frame_done <= (state_next == DONE);
      error      <= (state_next == ERR);
    end
  end

  // Clear address walks 0..SP_DEPTH-1, restarting from 0 on each accepted frame.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      clr_addr    <= '0;
      base_offset <= 1'b0;
    end else if (accept) begin
      clr_addr    <= '0;
      base_offset <= frame_base;
    end else if (state_reg == CLEAR && !clear_last) begin
      clr_addr    <= clr_addr + 1'b1;
    end
  end

  // cdf_min capture: first valid in HIST wins; fall back to the value seen with hist_done.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cdf_min_q    <= '0;
      cdf_seen_reg <= 1'b0;
    end else if (accept) begin
      cdf_seen_reg <= 1'b0;
    end else if (state_reg == HIST && !cdf_seen_reg) begin
      if (cdf_valid) begin
        cdf_min_q    <= cdf_min;
        cdf_seen_reg <= 1'b1;
      end else if (hist_done) begin
        cdf_min_q    <= cdf_min;
      end
    end
  end

endmodule
